ysyx_041461_clint: RTL and testbench

- Core-local interruptor that owns mtime/mtimecmp/msip and drives the WB-stage timer-interrupt input (WB_interrupt → mip.MTIP) plus a software-interrupt level.
- Sits on the data-memory side as a memory-mapped slave behind the MEM-stage address decoder, using a valid/ready request plus valid/ready response handshake.
- Decides when the pipeline's TIMER_INTERRUPT trap may be raised; trap entry itself stays in WB.

---
 rtl/ysyx_041461_clint_pkg.sv | 27 ++
 rtl/ysyx_041461_clint_tick.sv | 30 +++
 rtl/ysyx_041461_clint.sv | 142 ++++++++++++++
 tb/tb_ysyx_041461_clint.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_clint_pkg.sv
// Shared CLINT definitions: default window base, register offsets inside the
// 64 KiB window, bus FSM state encoding and the byte-strobe merge helper.
package ysyx_041461_clint_pkg;

  localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  // Replace the strobed bytes of cur with the matching bytes of wdata.
  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wmask);
    logic [63:0] merged;
    for (int i = 0; i < 8; i++) begin
      merged[i*8 +: 8] = wmask[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ysyx_041461_clint_tick.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
// While stop is high the count holds and no tick is issued.
module ysyx_041461_clint_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic stop,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !stop && (cnt == LAST);

  // Advance the divider; wrap to zero on the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (!stop) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_041461_clint.sv
// Core-local interruptor: memory-mapped msip / mtimecmp / mtime behind a
// valid/ready request and valid/ready response handshake, driving the
// timer-interrupt level for WB and the software-interrupt level.
// Optional build macro YSYX_041461_CLINT_STOP_EN adds a time_stop input that
// freezes the prescaler and mtime (bus writes to MTIME still land).
module ysyx_041461_clint
  import ysyx_041461_clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = CLINT_BASE_DEF,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef YSYX_041461_CLINT_STOP_EN
  input  logic        time_stop,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        clint_timer_irq,
  output logic        clint_soft_irq,
  output logic [63:0] clint_mtime
);

  clint_state_e state;
  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  logic         msip;
  logic         tick;
  logic         stop;

`ifdef YSYX_041461_CLINT_STOP_EN
  assign stop = time_stop;
`else
  assign stop = 1'b0;
`endif

  ysyx_041461_clint_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .stop (stop),
    .tick (tick)
  );

  // Address decode; addresses below the base wrap to a huge offset and miss.
  logic [63:0] off_full;
  logic [15:0] off;
  logic        in_win;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_time;
  logic        dec_err;
  logic [63:0] rd_val;
  logic [63:0] wr_merged;
  logic        accept;
  logic        do_wr;

  assign off_full  = req_addr - BASE_ADDR;
  assign off       = off_full[15:0];
  assign in_win    = (off_full[63:16] == '0);
  assign sel_msip  = in_win && (off == OFF_MSIP);
  assign sel_cmp   = in_win && (off == OFF_MTIMECMP);
  assign sel_time  = in_win && (off == OFF_MTIME);
  assign dec_err   = (req_addr[2:0] != 3'b000) || !(sel_msip || sel_cmp || sel_time);

  // Current (pre-edge) value of the selected register; shared by reads and
  // as the base that strobed write bytes are merged into.
  always_comb begin
    rd_val = '0;
    if (sel_msip)      rd_val = {63'd0, msip};
    else if (sel_cmp)  rd_val = mtimecmp;
    else if (sel_time) rd_val = mtime;
  end

  assign wr_merged = merge_bytes(rd_val, req_wdata, req_wmask);
  assign accept    = (state == ST_IDLE) && req_valid;
  assign do_wr     = accept && req_wen && !dec_err;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // Bus FSM: accept in IDLE, hold the response in RESP until consumed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_RESP;
            resp_rdata <= (req_wen || dec_err) ? 64'd0 : rd_val;
            resp_err   <= dec_err;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Timer/software registers; a bus write to mtime beats the tick increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime           <= '0;
      mtimecmp        <= '1;
      msip            <= 1'b0;
      clint_timer_irq <= 1'b0;
    end else begin
      if (do_wr && sel_time) begin
        mtime <= wr_merged;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (do_wr && sel_cmp) begin
        mtimecmp <= wr_merged;
      end
      if (do_wr && sel_msip) begin
        msip <= wr_merged[0];
      end
      clint_timer_irq <= (mtime >= mtimecmp);
    end
  end

  assign clint_soft_irq = msip;
  assign clint_mtime    = mtime;

endmodule

// File: tb/tb_ysyx_041461_clint.sv
// Directed bench for the CLINT with TICK_DIV=1: reset state, timer compare,
// decode errors, wrap, response back-pressure, msip and mid-transaction reset.
module tb_ysyx_041461_clint;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        clint_timer_irq;
  logic        clint_soft_irq;
  logic [63:0] clint_mtime;
`ifdef YSYX_041461_CLINT_STOP_EN
  logic        time_stop = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Edges since reset release; expected mtime = mt_base + (ncyc - mt_edge).
  logic [63:0] ncyc = '0;
  logic [63:0] mt_base = '0;
  logic [63:0] mt_edge = '0;

  ysyx_041461_clint #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef YSYX_041461_CLINT_STOP_EN
    .time_stop       (time_stop),
`endif
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wen         (req_wen),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .clint_timer_irq (clint_timer_irq),
    .clint_soft_irq  (clint_soft_irq),
    .clint_mtime     (clint_mtime)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) ncyc <= '0;
    else      ncyc <= ncyc + 64'd1;
  end

  function automatic logic [63:0] exp_mtime();
    return mt_base + (ncyc - mt_edge);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction: accept edge, response visible, consume edge.
  task automatic bus_xfer(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          output logic [63:0] rdata, output logic err);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0;
    if (wen && addr == A_TIME && wmask == 8'hFF) begin
      mt_base = wdata;
      mt_edge = ncyc;
    end
    check("resp_valid_lat1", {63'd0, resp_valid}, 64'd1);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_released", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_timer_irq", {63'd0, clint_timer_irq}, 64'd0);
    check("rst_soft_irq", {63'd0, clint_soft_irq}, 64'd0);
    check("rst_mtime", clint_mtime, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Free run then MTIMECMP=20
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mtime_5", clint_mtime, 64'd5);
    bus_xfer(1'b1, A_CMP, 64'd20, 8'hFF, rd, er);
    check("cmp_wr_err", {63'd0, er}, 64'd0);
    check("cmp_wr_rdata", rd, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mtime_10", clint_mtime, 64'd10);
    check("irq_at_10", {63'd0, clint_timer_irq}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("mtime_20", clint_mtime, 64'd20);
    check("irq_same_cycle", {63'd0, clint_timer_irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_rise", {63'd0, clint_timer_irq}, 64'd1);

    // Decode errors
    bus_xfer(1'b0, BASE + 64'h4004, 64'd0, 8'h00, rd, er);
    check("misalign_err", {63'd0, er}, 64'd1);
    check("misalign_rdata", rd, 64'd0);
    bus_xfer(1'b0, BASE + 64'h1000, 64'd0, 8'h00, rd, er);
    check("unmapped_err", {63'd0, er}, 64'd1);
    check("unmapped_rdata", rd, 64'd0);
    bus_xfer(1'b1, BASE + 64'h4004, 64'd0, 8'hFF, rd, er);
    check("misalign_wr_err", {63'd0, er}, 64'd1);
    bus_xfer(1'b1, BASE + 64'h1_4000, 64'd0, 8'hFF, rd, er);
    check("outside_wr_err", {63'd0, er}, 64'd1);
    bus_xfer(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
    check("cmp_unchanged", rd, 64'd20);
    check("cmp_rd_err", {63'd0, er}, 64'd0);

    // Back-pressure on a read of MTIME
    held = exp_mtime();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_TIME;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, held);
      check("hold_ready", {63'd0, req_ready}, 64'd0);
      check("hold_mtime_runs", clint_mtime, exp_mtime());
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Wrap with MTIMECMP=0
    bus_xfer(1'b1, A_CMP, 64'd0, 8'hFF, rd, er);
    bus_xfer(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    check("wrap_ff", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_irq_ff", {63'd0, clint_timer_irq}, 64'd1);
    @(posedge clk); #1;
    check("wrap_0", clint_mtime, 64'd0);
    check("wrap_irq_0", {63'd0, clint_timer_irq}, 64'd1);
    @(posedge clk); #1;
    check("wrap_irq_1", {63'd0, clint_timer_irq}, 64'd1);
    bus_xfer(1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("wrap_read_1", rd, 64'd1);

    // Byte-strobed MTIMECMP writes, including empty mask
    bus_xfer(1'b1, A_CMP, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, rd, er);
    check("merge_err", {63'd0, er}, 64'd0);
    bus_xfer(1'b1, A_CMP, 64'h1234_5678_9ABC_DEF0, 8'h00, rd, er);
    check("mask0_err", {63'd0, er}, 64'd0);
    bus_xfer(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
    check("merge_read", rd, 64'hAAAA_BBBB_0000_0000);
    check("irq_cleared", {63'd0, clint_timer_irq}, 64'd0);

    // MSIP
    bus_xfer(1'b1, A_MSIP, 64'd1, 8'h01, rd, er);
    check("soft_set", {63'd0, clint_soft_irq}, 64'd1);
    bus_xfer(1'b0, A_MSIP, 64'd0, 8'h00, rd, er);
    check("msip_read_1", rd, 64'd1);
    bus_xfer(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    check("soft_clr", {63'd0, clint_soft_irq}, 64'd0);
    bus_xfer(1'b0, A_MSIP, 64'd0, 8'h00, rd, er);
    check("msip_read_0", rd, 64'd0);

    // Reset while a response is pending
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_TIME;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_valid", {63'd0, resp_valid}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_rdata", resp_rdata, 64'd0);
    check("midrst_mtime", clint_mtime, 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    rst = 1'b1;
    mt_base = '0; mt_edge = '0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_mtime", clint_mtime, 64'd4);
    bus_xfer(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
    check("post_rst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
